// File: rtl/gpio_pattern_sequencer.sv
// APB-programmed GPIO pattern sequencer: walks up to DEPTH {data, mask, delay}
// entries and drives masked, timed updates onto seq_out.
module gpio_pattern_sequencer #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int DEPTH          = 8,
    parameter int DELAY_WIDTH    = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [31:0]               seq_out,
    output logic                      seq_busy,
    output logic                      interrupt
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          cur_q, cur_d;
    logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
    logic                   fin_q, fin_d;
    logic                   start_q, start_d;
    logic                   loop_q, loop_d;
    logic                   ie_q, ie_d;
    logic                   done_q, done_d;
    logic [7:0]             len_q, len_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [31:0]            seq_out_q, seq_out_d;
    logic [31:0]            data_q [DEPTH];
    logic [31:0]            data_d [DEPTH];
    logic [31:0]            mask_q [DEPTH];
    logic [31:0]            mask_d [DEPTH];
    logic [DELAY_WIDTH-1:0] delay_q [DEPTH];
    logic [DELAY_WIDTH-1:0] delay_d [DEPTH];

    logic       wr, start_req, stop_req, wr_out;
    logic       done_set, apply_en, advance;
    logic [3:0] reg_sel;
    logic [8:0] eff_len, nxt_idx;
    logic       unused_paddr;

    assign reg_sel      = PADDR[5:2];
    assign wr           = PSEL && PENABLE && PWRITE;
    assign stop_req     = wr && (reg_sel == 4'h0) && PWDATA[1];
    assign start_req    = wr && (reg_sel == 4'h0) && PWDATA[0] && !PWDATA[1];
    assign wr_out       = wr && (reg_sel == 4'h7);
    assign eff_len      = ({1'b0, len_q} > 9'(DEPTH)) ? 9'(DEPTH) : {1'b0, len_q};
    assign nxt_idx      = 9'(cur_q) + 9'd1;
    assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            start_q   <= 1'b0;
            loop_q    <= 1'b0;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            len_q     <= '0;
            idx_q     <= '0;
            seq_out_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                mask_q[i]  <= '0;
                delay_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            fin_q     <= fin_d;
            start_q   <= start_d;
            loop_q    <= loop_d;
            ie_q      <= ie_d;
            done_q    <= done_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            seq_out_q <= seq_out_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            delay_q   <= delay_d;
        end
    end

    // An accepted START is held one cycle in start_q before the walk begins;
    // fin_q spends one APPLY slot so completion lands DELAY+1 after the last entry.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        fin_d     = fin_q;
        start_d   = 1'b0;
        done_set  = 1'b0;
        apply_en  = 1'b0;
        advance   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_q) begin
                    state_d = S_APPLY;
                    cur_d   = '0;
                end else begin
                    start_d = start_req && (eff_len != 9'd0);
                end
            end
            S_APPLY: begin
                if (fin_q) begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                    cur_d    = '0;
                    fin_d    = 1'b0;
                end else begin
                    apply_en = 1'b1;
                    cnt_d    = delay_q[cur_q];
                    if (delay_q[cur_q] != '0) state_d = S_WAIT;
                    else                      advance = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == DELAY_WIDTH'(1)) advance = 1'b1;
                else                          cnt_d   = cnt_q - DELAY_WIDTH'(1);
            end
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            state_d = S_APPLY;
            if (nxt_idx < eff_len) cur_d = cur_q + IW'(1);
            else if (loop_q)       cur_d = '0;
            else                   fin_d = 1'b1;
        end
        if (stop_req) begin
            state_d  = S_IDLE;
            cur_d    = '0;
            fin_d    = 1'b0;
            start_d  = 1'b0;
            done_set = 1'b0;
            apply_en = 1'b0;
        end
        seq_out_d = seq_out_q;
        if (apply_en)
            seq_out_d = (seq_out_q & ~mask_q[cur_q]) | (data_q[cur_q] & mask_q[cur_q]);
        else if (wr_out && !seq_busy)
            seq_out_d = PWDATA;
    end

    always_comb begin
        loop_d  = loop_q;
        ie_d    = ie_q;
        len_d   = len_q;
        idx_d   = idx_q;
        done_d  = done_q;
        data_d  = data_q;
        mask_d  = mask_q;
        delay_d = delay_q;
        if (wr) begin
            case (reg_sel)
                4'h0: begin
                    loop_d = PWDATA[2];
                    ie_d   = PWDATA[3];
                end
                4'h1: if (PWDATA[1]) done_d = 1'b0;
                4'h2: len_d = PWDATA[7:0];
                4'h3: idx_d = PWDATA[IW-1:0];
                4'h4: data_d[idx_q]  = PWDATA;
                4'h5: mask_d[idx_q]  = PWDATA;
                4'h6: delay_d[idx_q] = PWDATA[DELAY_WIDTH-1:0];
                default: ;
            endcase
        end
        if (done_set) done_d = 1'b1;
    end

    always_comb begin
        PRDATA = '0;
        case (reg_sel)
            4'h0: PRDATA = {28'd0, ie_q, loop_q, 2'b00};
            4'h1: PRDATA = {16'd0, 8'(cur_q), 6'd0, done_q, seq_busy};
            4'h2: PRDATA = {24'd0, len_q};
            4'h3: PRDATA = 32'(idx_q);
            4'h4: PRDATA = data_q[idx_q];
            4'h5: PRDATA = mask_q[idx_q];
            4'h6: PRDATA = 32'(delay_q[idx_q]);
            4'h7: PRDATA = seq_out_q;
            default: PRDATA = '0;
        endcase
    end

    assign seq_busy  = (state_q != S_IDLE) || start_q;
    assign seq_out   = seq_out_q;
    assign interrupt = done_q && ie_q;
    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// Directed and randomized checks of gpio_pattern_sequencer against a schedule
// model built from the entry timing rules.
module tb_gpio_pattern_sequencer;
    localparam int DEPTH = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [31:0] seq_out;
    logic        seq_busy, interrupt;

    int n_cmp = 0;
    int n_err = 0;

    gpio_pattern_sequencer #(.APB_ADDR_WIDTH(12), .DEPTH(DEPTH), .DELAY_WIDTH(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .seq_out(seq_out),
        .seq_busy(seq_busy), .interrupt(interrupt)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Setup at one negedge, access at the next; the write lands on the posedge
    // in between and the task returns at the negedge just after that edge.
    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge HCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        PSEL = 1'b0; PWRITE = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        #1 d = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic set_entry(input int k, input logic [31:0] d, input logic [31:0] m,
                             input logic [31:0] dl);
        apb_wr(12'h00C, k);
        apb_wr(12'h010, d);
        apb_wr(12'h014, m);
        apb_wr(12'h018, dl);
    endtask

    logic [31:0] rd, base, mv, exp_v;
    logic [31:0] ed [DEPTH];
    logic [31:0] em [DEPTH];
    int          edl [DEPTH];
    logic [31:0] q_out [$];
    bit          q_busy [$];
    bit          q_int [$];
    int          len_r, eff;
    bit          ie;

    initial begin
        HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        // reset state
        chk("rst_seq_out", seq_out, 32'h0);
        chk("rst_busy", {31'd0, seq_busy}, 32'h0);
        chk("rst_irq", {31'd0, interrupt}, 32'h0);
        chk("pready", {31'd0, PREADY}, 32'h1);
        chk("pslverr", {31'd0, PSLVERR}, 32'h0);
        for (int a = 0; a < 9; a++) begin
            apb_rd(12'(a * 4), rd);
            chk($sformatf("rst_reg_%02h", a * 4), rd, 32'h0);
        end
        apb_wr(12'h00C, 32'h9);
        apb_rd(12'h00C, rd);
        chk("idx_upper_ignored", rd, 32'h1);

        // basic two-entry run with interrupt
        set_entry(0, 32'h0000_00FF, 32'h0000_000F, 3);
        set_entry(1, 32'hA500_0000, 32'hFF00_0000, 0);
        apb_wr(12'h008, 2);
        apb_wr(12'h000, 32'h9);
        chk("run1_o0_busy", {31'd0, seq_busy}, 32'h1);
        for (int o = 1; o <= 7; o++) begin
            @(negedge HCLK);
            exp_v = (o < 2) ? 32'h0 : (o < 6) ? 32'h0000_000F : 32'hA500_000F;
            chk($sformatf("run1_out_o%0d", o), seq_out, exp_v);
            chk($sformatf("run1_busy_o%0d", o), {31'd0, seq_busy}, (o < 7) ? 32'h1 : 32'h0);
            chk($sformatf("run1_irq_o%0d", o), {31'd0, interrupt}, (o == 7) ? 32'h1 : 32'h0);
        end
        apb_rd(12'h004, rd);
        chk("run1_status", rd, 32'h2);
        apb_rd(12'h000, rd);
        chk("run1_ctrl", rd, 32'h8);
        apb_wr(12'h004, 32'h2);
        chk("w1c_irq", {31'd0, interrupt}, 32'h0);

        // looping toggle on bit0, then STOP while in WAIT
        set_entry(0, 32'h1, 32'h1, 1);
        set_entry(1, 32'h0, 32'h1, 1);
        apb_wr(12'h000, 32'hD);
        for (int o = 1; o <= 12; o++) begin
            @(negedge HCLK);
            exp_v = (o < 2 || (((o - 2) / 2) % 2) == 0) ? 32'hA500_000F : 32'hA500_000E;
            chk($sformatf("loop_out_o%0d", o), seq_out, exp_v);
            chk($sformatf("loop_busy_o%0d", o), {31'd0, seq_busy}, 32'h1);
        end
        apb_wr(12'h000, 32'h2);
        for (int o = 0; o < 5; o++) begin
            if (o > 0) @(negedge HCLK);
            chk($sformatf("stop_busy_%0d", o), {31'd0, seq_busy}, 32'h0);
            chk($sformatf("stop_frozen_%0d", o), seq_out, 32'hA500_000F);
        end
        apb_rd(12'h004, rd);
        chk("stop_status", rd, 32'h0);

        // START with LEN=0, then START+STOP together
        apb_wr(12'h008, 0);
        apb_wr(12'h000, 32'h1);
        for (int o = 0; o < 3; o++) begin
            @(negedge HCLK);
            chk($sformatf("len0_busy_%0d", o), {31'd0, seq_busy}, 32'h0);
        end
        chk("len0_out", seq_out, 32'hA500_000F);
        apb_wr(12'h008, 2);
        apb_wr(12'h000, 32'h3);
        for (int o = 0; o < 3; o++) begin
            @(negedge HCLK);
            chk($sformatf("startstop_busy_%0d", o), {31'd0, seq_busy}, 32'h0);
        end
        chk("startstop_out", seq_out, 32'hA500_000F);

        // OUT write while idle, then START and OUT while busy
        apb_wr(12'h01C, 32'h1234_5678);
        chk("out_idle", seq_out, 32'h1234_5678);
        apb_rd(12'h01C, rd);
        chk("out_read", rd, 32'h1234_5678);
        set_entry(0, 32'h0000_00FF, 32'h0000_000F, 3);
        set_entry(1, 32'hA500_0000, 32'hFF00_0000, 0);
        apb_wr(12'h000, 32'h9);
        chk("busy_o0_out", seq_out, 32'h1234_5678);
        apb_wr(12'h000, 32'h9);
        chk("restart_o3_out", seq_out, 32'h1234_567F);
        chk("restart_o3_busy", {31'd0, seq_busy}, 32'h1);
        apb_wr(12'h01C, 32'hDEAD_BEEF);
        chk("outbusy_o6_out", seq_out, 32'hA534_567F);
        @(negedge HCLK);
        chk("restart_o7_busy", {31'd0, seq_busy}, 32'h0);
        chk("restart_o7_irq", {31'd0, interrupt}, 32'h1);
        chk("restart_o7_out", seq_out, 32'hA534_567F);
        apb_wr(12'h004, 32'h2);

        // randomized single-pass runs against the timing schedule
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                ed[k]  = $urandom;
                em[k]  = $urandom;
                edl[k] = $urandom_range(0, 3);
                set_entry(k, ed[k], em[k], edl[k]);
            end
            len_r = $urandom_range(1, DEPTH + 2);
            eff   = (len_r > DEPTH) ? DEPTH : len_r;
            ie    = 1'($urandom_range(0, 1));
            base  = $urandom;
            apb_wr(12'h008, len_r);
            apb_wr(12'h01C, base);
            q_out.delete(); q_busy.delete(); q_int.delete();
            mv = base;
            q_out.push_back(mv); q_busy.push_back(1'b1); q_int.push_back(1'b0);
            q_out.push_back(mv); q_busy.push_back(1'b1); q_int.push_back(1'b0);
            for (int k = 0; k < eff; k++) begin
                mv = (mv & ~em[k]) | (ed[k] & em[k]);
                for (int c = 0; c <= edl[k]; c++) begin
                    q_out.push_back(mv); q_busy.push_back(1'b1); q_int.push_back(1'b0);
                end
            end
            q_out.push_back(mv); q_busy.push_back(1'b0); q_int.push_back(ie);
            apb_wr(12'h000, {28'd0, ie, 3'b001});
            for (int o = 0; o < q_out.size(); o++) begin
                if (o > 0) @(negedge HCLK);
                chk($sformatf("rnd%0d_out_o%0d", r, o), seq_out, q_out[o]);
                chk($sformatf("rnd%0d_busy_o%0d", r, o), {31'd0, seq_busy}, {31'd0, q_busy[o]});
                chk($sformatf("rnd%0d_irq_o%0d", r, o), {31'd0, interrupt}, {31'd0, q_int[o]});
            end
            apb_wr(12'h004, 32'h2);
        end

        // asynchronous reset during WAIT, then a fresh run from entry 0
        set_entry(0, 32'hCAFE_F00D, 32'hFFFF_0000, 5);
        set_entry(1, 32'h0000_BEEF, 32'h0000_FFFF, 0);
        apb_wr(12'h008, 2);
        apb_wr(12'h000, 32'h1);
        repeat (3) @(negedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_out", seq_out, 32'h0);
        chk("arst_busy", {31'd0, seq_busy}, 32'h0);
        chk("arst_irq", {31'd0, interrupt}, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        apb_rd(12'h008, rd);
        chk("arst_len", rd, 32'h0);
        apb_rd(12'h010, rd);
        chk("arst_data0", rd, 32'h0);
        set_entry(0, 32'h0000_0055, 32'h0000_00FF, 2);
        set_entry(1, 32'h0000_1100, 32'h0000_FF00, 0);
        apb_wr(12'h008, 2);
        apb_wr(12'h000, 32'h1);
        for (int o = 1; o <= 6; o++) begin
            @(negedge HCLK);
            exp_v = (o < 2) ? 32'h0 : (o < 5) ? 32'h0000_0055 : 32'h0000_1155;
            chk($sformatf("post_rst_out_o%0d", o), seq_out, exp_v);
            chk($sformatf("post_rst_busy_o%0d", o), {31'd0, seq_busy}, (o < 6) ? 32'h1 : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
